// File: rtl/mux_pkg.sv
// Shared types and default sizing for the arbitrating output mux.
package mux_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_N     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the first set request at or after
// base (wrapping) wins. Fixed priority is base tied to zero.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IDXW = $clog2(N);

  int              j;
  logic [IDXW-1:0] idx;

  // Scan offsets 0..N-1 from base; the first hit locks out later candidates.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(base) + k;
      if (j >= N) j = j - N;
      idx = j[IDXW-1:0];
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered mux: arbitrates among valid producers and loads the
// winner into a single output register with valid/ready on both sides.
module arb_mux
  import mux_pkg::*;
#(
  parameter int        WIDTH = DEFAULT_WIDTH,
  parameter int        N     = DEFAULT_N,
  parameter arb_mode_t MODE  = ARB_RR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_ch,
  input  logic                 out_ready
);

  localparam int              IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  base;
  logic [IDXW-1:0]  gnt_idx;
  logic [N-1:0]     gnt;
  logic             any;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign base = (MODE == ARB_RR) ? ptr : '0;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .base    (base),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // The output register can accept a beat when empty or being drained now.
  assign load     = !out_valid || out_ready;
  assign take     = load && any && !reset;
  assign in_ready = take ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_ch    <= gnt_idx;
        if (MODE == ARB_RR)
          ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + IDXW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: a round-robin instance checked through a
// behavioural model and scoreboard, plus a fixed-priority instance.
module tb_arb_mux;
  import mux_pkg::*;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_valid;
  logic [15:0] in_data;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_ch;
  logic       out_ready;

  logic [3:0] f_in_valid;
  logic [3:0] f_in_ready;
  logic       f_out_valid;
  logic [3:0] f_out_data;
  logic [1:0] f_out_ch;
  logic       f_out_ready;

  logic [3:0] chval [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  beat_t      sb [$];
  beat_t      m_beat;
  beat_t      exp_b;
  logic [1:0] m_ptr;
  logic       m_ov;
  logic [3:0] exp_rdy;
  logic [3:0] obs_rdy;
  logic       granted;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign in_data = {chval[3], chval[2], chval[1], chval[0]};

  arb_mux #(.WIDTH(4), .N(4), .MODE(ARB_RR)) dut_rr (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(4), .N(4), .MODE(ARB_FIXED)) dut_fx (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (f_in_valid),
    .in_data   (in_data),
    .in_ready  (f_in_ready),
    .out_valid (f_out_valid),
    .out_data  (f_out_data),
    .out_ch    (f_out_ch),
    .out_ready (f_out_ready)
  );

  function automatic int pick(input logic [3:0] v, input logic [1:0] base);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(base) + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // One cycle on the RR instance: drive at negedge, sample in_ready before the
  // edge, advance the model (pushing any expected beat), sample after the edge.
  task automatic drive(input logic [3:0] v, input logic ordy);
    int w;
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    #1;
    obs_rdy = in_ready;
    exp_rdy = '0;
    granted = 1'b0;
    if (!m_ov || ordy) begin
      w = pick(v, m_ptr);
      if (w >= 0) begin
        exp_rdy[w[1:0]] = 1'b1;
        granted         = 1'b1;
        m_beat.ch       = w[1:0];
        m_beat.data     = chval[w[1:0]];
        sb.push_back(m_beat);
        m_ov  = 1'b1;
        m_ptr = w[1:0] + 2'd1;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    f_in_valid = 4'b1111; f_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000 || f_in_ready !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL reset_in_ready rr=%b fx=%b expected 0000", in_ready, f_in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || f_out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_out_valid rr=%b fx=%b expected 0", out_valid, f_out_valid);
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = '0; f_in_valid = '0;
    m_ptr = '0; m_ov = 1'b0; sb.delete();
  endtask

  task automatic test_rr_fairness();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1);
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL rr_in_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (out_valid !== m_ov) begin
        n_fail++;
        $display("[TB] FAIL rr_out_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov);
      end
      if (granted) begin
        exp_b = sb.pop_front();
        n_cmp++;
        if (out_ch !== exp_b.ch || out_data !== exp_b.data) begin
          n_fail++;
          $display("[TB] FAIL rr_beat cyc=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                   i, out_ch, out_data, exp_b.ch, exp_b.data);
        end
      end
    end
  endtask

  task automatic test_fixed();
    @(negedge clk);
    f_in_valid = 4'b1010; f_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (f_in_ready !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL fixed_in_ready cyc=%0d got=%b exp=0010", i, f_in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (f_out_valid !== 1'b1 || f_out_ch !== 2'd1 || f_out_data !== 4'hB) begin
        n_fail++;
        $display("[TB] FAIL fixed_beat cyc=%0d got v=%b ch=%0d data=%h exp v=1 ch=1 data=b",
                 i, f_out_valid, f_out_ch, f_out_data);
      end
      @(negedge clk);
    end
    f_in_valid = '0;
  endtask

  // Stalled ch2 beat must sit still; releasing with ch0+ch3 valid picks ch3
  // (pointer still 3) as a same-edge reload.
  task automatic test_backpressure();
    logic [3:0] vals [5] = '{4'b0100, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
    logic       rdys [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(vals[i], rdys[i]);
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL bp_in_ready step=%0d got=%b exp=%b", i, obs_rdy, exp_rdy);
      end
      exp_b = granted ? sb.pop_front() : m_beat;
      n_cmp++;
      if (out_valid !== m_ov || out_ch !== exp_b.ch || out_data !== exp_b.data) begin
        n_fail++;
        $display("[TB] FAIL bp_beat step=%0d got v=%b ch=%0d data=%h exp v=%b ch=%0d data=%h",
                 i, out_valid, out_ch, out_data, m_ov, exp_b.ch, exp_b.data);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] vals [4] = '{4'b0100, 4'b0001, 4'b0000, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      drive(vals[i], 1'b1);
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL wrap_in_ready step=%0d got=%b exp=%b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (out_valid !== m_ov) begin
        n_fail++;
        $display("[TB] FAIL wrap_out_valid step=%0d got=%b exp=%b", i, out_valid, m_ov);
      end
      if (granted) begin
        exp_b = sb.pop_front();
        n_cmp++;
        if (out_ch !== exp_b.ch || out_data !== exp_b.data) begin
          n_fail++;
          $display("[TB] FAIL wrap_beat step=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                   i, out_ch, out_data, exp_b.ch, exp_b.data);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(4'b0010, 1'b1);
    if (granted) exp_b = sb.pop_front();
    drive(4'b0000, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 4'hB) begin
      n_fail++;
      $display("[TB] FAIL mid_stall got v=%b ch=%0d data=%h exp v=1 ch=1 data=b",
               out_valid, out_ch, out_data);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_in_ready got=%b exp=0000", in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_clear got v=%b ch=%0d data=%h exp v=0 ch=0 data=0",
               out_valid, out_ch, out_data);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = '0;
    m_ptr = '0; m_ov = 1'b0; sb.delete();
    drive(4'b1111, 1'b1);
    n_cmp++;
    if (obs_rdy !== 4'b0001 || exp_rdy !== obs_rdy) begin
      n_fail++;
      $display("[TB] FAIL post_reset_in_ready got=%b exp=%b", obs_rdy, exp_rdy);
    end
    if (granted) begin
      exp_b = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== exp_b.ch || out_data !== exp_b.data) begin
        n_fail++;
        $display("[TB] FAIL post_reset_beat got v=%b ch=%0d data=%h exp v=1 ch=%0d data=%h",
                 out_valid, out_ch, out_data, exp_b.ch, exp_b.data);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0;
    f_in_valid = '0; f_out_ready = 1'b0;
    m_ptr = '0; m_ov = 1'b0; m_beat = '0; exp_b = '0;
    exp_rdy = '0; obs_rdy = '0; granted = 1'b0;
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
